// File: rtl/spi_temp_reader.sv
// spi_temp_reader: read-only SPI master (mode 0). It reads one 16-bit frame
// from the temperature sensor on each rising edge of the timer trigger and
// presents the top TEMP_BITS of the frame with a one-cycle valid strobe.
module spi_temp_reader #(
  parameter int CLK_DIV    = 25,
  parameter int FRAME_BITS = 16,
  parameter int TEMP_BITS  = 13
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 trig_in,
  input  logic                 miso_in,
  output logic                 cs_n_out,
  output logic                 sclk_out,
  output logic [TEMP_BITS-1:0] temp_out,
  output logic                 temp_valid_out,
  output logic                 busy_out,
  output logic                 trig_miss_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [DIV_W-1:0]        r_div;
  logic [BIT_W-1:0]        r_bit;
  logic                    r_high;
  logic                    r_trig_prev;
  logic                    r_edge;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_cs_n;
  logic                    r_sclk;
  logic [TEMP_BITS-1:0]    r_temp;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_miss;

  state_t                  w_state_nxt;
  logic [DIV_W-1:0]        w_div_nxt;
  logic [BIT_W-1:0]        w_bit_nxt;
  logic                    w_high_nxt;
  logic                    w_sclk_nxt;
  logic                    w_sample;
  logic                    w_div_last;
  logic                    w_cs_idle_nxt;

  assign w_div_last    = (r_div == DIV_MAX);
  assign w_cs_idle_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);

  // Next-state, divider/bit counters and next SCLK level.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_high_nxt  = r_high;
    w_sclk_nxt  = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (r_edge) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_state_nxt = S_SHIFT;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_high_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        w_sclk_nxt = r_high;
        if (w_div_last) begin
          w_div_nxt = '0;
          if (!r_high) begin
            // SCLK rises on this edge; MISO is captured on the same edge.
            w_high_nxt = 1'b1;
            w_sclk_nxt = 1'b1;
            w_sample   = 1'b1;
          end else if (r_bit == BIT_MAX) begin
            w_state_nxt = S_HOLD;
            w_high_nxt  = 1'b0;
            w_sclk_nxt  = 1'b0;
          end else begin
            w_bit_nxt  = r_bit + BIT_W'(1);
            w_high_nxt = 1'b0;
            w_sclk_nxt = 1'b0;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (w_div_last) begin
          w_state_nxt = S_DONE;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_high  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_high  <= w_high_nxt;
    end
  end

  // Trigger edge detect, shift register and registered outputs.
  // Outputs are computed from the next state so they line up with the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_trig_prev <= 1'b1;
      r_edge      <= 1'b0;
      r_shift     <= '0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
      r_temp      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_trig_prev <= trig_in;
      r_edge      <= trig_in && !r_trig_prev;
      if (w_sample) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], miso_in};
      end
      r_cs_n  <= w_cs_idle_nxt;
      r_busy  <= !w_cs_idle_nxt;
      r_sclk  <= w_sclk_nxt;
      r_valid <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        r_temp <= r_shift[FRAME_BITS-1 -: TEMP_BITS];
      end
      r_miss  <= r_edge && (r_state != S_IDLE);
    end
  end

  assign cs_n_out       = r_cs_n;
  assign sclk_out       = r_sclk;
  assign temp_out       = r_temp;
  assign temp_valid_out = r_valid;
  assign busy_out       = r_busy;
  assign trig_miss_out  = r_miss;

endmodule

// File: tb/tb_spi_temp_reader.sv
// Bench for spi_temp_reader with CLK_DIV=2 and a sensor model that shifts
// out a 16-bit frame MSB first, changing data on SCLK falling edges.
module tb_spi_temp_reader;

  logic        clk;
  logic        rst;
  logic        trig;
  logic        miso;
  logic        cs_n_out;
  logic        sclk_out;
  logic [12:0] temp_out;
  logic        temp_valid_out;
  logic        busy_out;
  logic        trig_miss_out;

  spi_temp_reader #(
    .CLK_DIV   (2),
    .FRAME_BITS(16),
    .TEMP_BITS (13)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .trig_in       (trig),
    .miso_in       (miso),
    .cs_n_out      (cs_n_out),
    .sclk_out      (sclk_out),
    .temp_out      (temp_out),
    .temp_valid_out(temp_valid_out),
    .busy_out      (busy_out),
    .trig_miss_out (trig_miss_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor model
  logic [15:0] sens_frame = 16'h0000;
  int          bitidx = 0;

  always @(negedge sclk_out or posedge cs_n_out) begin
    if (cs_n_out) bitidx = 0;
    else          bitidx = bitidx + 1;
  end

  always_comb begin
    miso = 1'b0;
    if (bitidx >= 0 && bitidx < 16) miso = sens_frame[15 - bitidx];
  end

  // Free-running event counters; tests look at deltas.
  int n_rise  = 0;
  int n_cslow = 0;
  int n_valid = 0;
  int n_miss  = 0;

  always @(posedge sclk_out) n_rise = n_rise + 1;

  always @(negedge clk) begin
    if (cs_n_out === 1'b0)       n_cslow = n_cslow + 1;
    if (temp_valid_out === 1'b1) n_valid = n_valid + 1;
    if (trig_miss_out === 1'b1)  n_miss  = n_miss + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for the valid strobe and checks it against the scoreboard.
  task automatic wait_done();
    bit got;
    logic [12:0] e;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (temp_valid_out === 1'b1) got = 1'b1;
    end
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("temp_out", 32'(temp_out), 32'(e));
      check("busy_at_done", 32'(busy_out), 32'd0);
      check("cs_n_at_done", 32'(cs_n_out), 32'd1);
      @(negedge clk);
      check("valid_falls", 32'(temp_valid_out), 32'd0);
    end
  endtask

  task automatic run_frame(input logic [15:0] frame, input logic [12:0] exp_t,
                           input bit retrig, input int exp_miss);
    int s_rise, s_cs, s_val, s_miss;
    sens_frame = frame;
    exp_q.push_back(exp_t);
    s_rise = n_rise; s_cs = n_cslow; s_val = n_valid; s_miss = n_miss;
    trig = 1'b1;
    tick(1);
    check("cs_n_before_start", 32'(cs_n_out), 32'd1);
    trig = 1'b0;
    tick(1);
    check("cs_n_start", 32'(cs_n_out), 32'd0);
    check("busy_start", 32'(busy_out), 32'd1);
    if (retrig) begin
      tick(30);
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
    end
    wait_done();
    tick(4);
    check("sclk_rises", 32'(n_rise - s_rise), 32'd16);
    check("cs_low_cycles", 32'(n_cslow - s_cs), 32'd68);
    check("valid_pulses", 32'(n_valid - s_val), 32'd1);
    check("miss_pulses", 32'(n_miss - s_miss), 32'(exp_miss));
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [12:0] temp;
    bit          retrig;
    int          miss;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s_rise, s_cs, s_val, s_miss;

    vecs[0] = '{16'h0C80, 13'h0190, 1'b0, 0};
    vecs[1] = '{16'hE700, 13'h1CE0, 1'b0, 0};
    vecs[2] = '{16'h0C80, 13'h0190, 1'b1, 1};
    vecs[3] = '{16'h7FFF, 13'h0FFF, 1'b0, 0};
    vecs[4] = '{16'h8000, 13'h1000, 1'b0, 0};
    vecs[5] = '{16'hA5A5, 13'h14B4, 1'b0, 0};

    // Reset, then idle
    rst  = 1'b1;
    trig = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_cs_n", 32'(cs_n_out), 32'd1);
    check("rst_sclk", 32'(sclk_out), 32'd0);
    check("rst_temp", 32'(temp_out), 32'd0);
    check("rst_valid", 32'(temp_valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_miss", 32'(trig_miss_out), 32'd0);
    s_rise = n_rise; s_cs = n_cslow; s_val = n_valid; s_miss = n_miss;
    tick(100);
    check("idle_rises", 32'(n_rise - s_rise), 32'd0);
    check("idle_cslow", 32'(n_cslow - s_cs), 32'd0);
    check("idle_valid", 32'(n_valid - s_val), 32'd0);
    check("idle_miss", 32'(n_miss - s_miss), 32'd0);
    check("idle_temp", 32'(temp_out), 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].frame, vecs[i].temp, vecs[i].retrig, vecs[i].miss);
      tick(3);
    end

    // Reset around bit 8 of a transaction
    sens_frame = 16'hE700;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(37);
    check("pre_rst_busy", 32'(busy_out), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_cs_n", 32'(cs_n_out), 32'd1);
    check("midrst_sclk", 32'(sclk_out), 32'd0);
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_temp", 32'(temp_out), 32'd0);
    s_val = n_valid; s_cs = n_cslow;
    tick(150);
    check("midrst_no_valid", 32'(n_valid - s_val), 32'd0);
    check("midrst_no_cs", 32'(n_cslow - s_cs), 32'd0);

    // Trigger held high across reset release
    trig = 1'b1;
    rst  = 1'b1;
    tick(3);
    rst = 1'b0;
    s_cs = n_cslow; s_val = n_valid;
    tick(1000);
    check("held_no_cs", 32'(n_cslow - s_cs), 32'd0);
    check("held_no_valid", 32'(n_valid - s_val), 32'd0);
    check("held_busy", 32'(busy_out), 32'd0);
    trig = 1'b0;
    tick(2);
    sens_frame = 16'hE700;
    exp_q.push_back(13'h1CE0);
    trig = 1'b1;
    tick(1);
    check("held_cs_before", 32'(cs_n_out), 32'd1);
    tick(1);
    check("held_cs_start", 32'(cs_n_out), 32'd0);
    wait_done();
    trig = 1'b0;
    tick(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
